// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480@60 raster geometry, derived totals and sync-level helper.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 10;

  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  localparam logic SYNC_ACTIVE_LOW = 1'b0;

  // Pad level for a sync signal given its active polarity.
  function automatic logic sync_level(input logic pol, input logic active);
    return active ? pol : ~pol;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Free-running VGA raster counters with registered, zero-skew decode flags.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = SYNC_ACTIVE_LOW,
  parameter logic VS_POL   = SYNC_ACTIVE_LOW,
  parameter int   CNT_W    = DEF_CNT_W
) (
  input  logic             clk_25mhz,
  input  logic             rst,
  output logic             hsync,
  output logic             vsync,
  output logic             de_enable,
  output logic             line_end,
  output logic             frame_end,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // One extra bit so that an end boundary equal to 2^CNT_W still compares correctly.
  localparam logic [CNT_W:0] H_ACT_X    = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] V_ACT_X    = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] HS_START_X = (CNT_W+1)'(HS_START);
  localparam logic [CNT_W:0] HS_END_X   = (CNT_W+1)'(HS_END);
  localparam logic [CNT_W:0] VS_START_X = (CNT_W+1)'(VS_START);
  localparam logic [CNT_W:0] VS_END_X   = (CNT_W+1)'(VS_END);

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_cnt_w_check
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic             h_wrap;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic [CNT_W:0]   h_ext;
  logic [CNT_W:0]   v_ext;

  always_comb begin
    h_wrap = (hcount == H_LAST);
    h_next = h_wrap ? '0 : hcount + 1'b1;
    v_next = vcount;
    if (h_wrap) begin
      v_next = (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end
    h_ext = {1'b0, h_next};
    v_ext = {1'b0, v_next};
  end

  // Flags are decoded from the next counter values so they land in the same
  // cycle as the coordinates they describe. Reset parks the counters on the
  // last pixel of the frame, so the first free-running edge yields (0,0).
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      hcount    <= H_LAST;
      vcount    <= V_LAST;
      de_enable <= 1'b0;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
      hsync     <= sync_level(HS_POL, 1'b0);
      vsync     <= sync_level(VS_POL, 1'b0);
    end else begin
      hcount    <= h_next;
      vcount    <= v_next;
      de_enable <= (h_ext < H_ACT_X) && (v_ext < V_ACT_X);
      line_end  <= (h_next == H_LAST);
      frame_end <= (h_next == H_LAST) && (v_next == V_LAST);
      hsync     <= sync_level(HS_POL, (h_ext >= HS_START_X) && (h_ext < HS_END_X));
      vsync     <= sync_level(VS_POL, (v_ext >= VS_START_X) && (v_ext < VS_END_X));
    end
  end

endmodule

`default_nettype wire
